// File: rtl/bit_packer.sv
// Serial-to-parallel packer: one bit per cycle into an indexed word slot,
// completed words held in a one-entry output register with a running sum.
module bit_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH+1)-1:0] out_nbits,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           sum
);

  localparam int IW = $clog2(WIDTH);
  localparam int NW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] asm_word;
  logic [WIDTH-1:0] merged;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    pos;
  logic [NW-1:0]    nbits;
  logic             done;
  logic             accept;
  logic             fire;

  // Stall only a completing bit, and only while the held word is blocked.
  always_comb begin
    done     = (idx == IW'(WIDTH - 1)) || in_last;
    in_ready = !(out_valid && !out_ready && done);
    accept   = in_valid && in_ready;
    fire     = out_valid && out_ready;
    pos      = MSB_FIRST ? (IW'(WIDTH - 1) - idx) : idx;
    merged   = asm_word;
    merged[pos] = in_bit;
    nbits    = NW'(idx) + NW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_word  <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      sum       <= '0;
    end else begin
      if (fire) begin
        sum       <= sum + out_data;
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (done) begin
          out_data  <= merged;
          out_nbits <= nbits;
          out_valid <= 1'b1;
          asm_word  <= '0;
          idx       <= '0;
        end else begin
          asm_word  <= merged;
          idx       <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Randomised and directed bench for bit_packer, LSB-first and MSB-first
// instances driven in parallel against a word-level reference model.
module tb_bit_packer;

  localparam int W  = 8;
  localparam int NW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic          rdy0, rdy1;
  logic          ov0, ov1;
  logic [W-1:0]  od0, od1;
  logic [NW-1:0] nb0, nb1;
  logic [W-1:0]  s0, s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_last(in_last), .in_ready(rdy0), .out_valid(ov0),
    .out_data(od0), .out_nbits(nb0), .out_ready(out_ready), .sum(s0)
  );

  bit_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_last(in_last), .in_ready(rdy1), .out_valid(ov1),
    .out_data(od1), .out_nbits(nb1), .out_ready(out_ready), .sum(s1)
  );

  // Reference model: list of received bits, held word, running sums.
  int           mbits[W];
  int           mn = 0;
  logic         mvalid = 1'b0;
  logic [W-1:0] mw0 = '0, mw1 = '0;
  int           mnb = 0;
  logic [W-1:0] ms0 = '0, ms1 = '0;
  logic         exp_rdy, obs_rdy0, obs_rdy1;

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mn = 0; mvalid = 1'b0; mw0 = '0; mw1 = '0;
    mnb = 0; ms0 = '0; ms1 = '0;
  endtask

  task automatic step(input logic v, input logic b,
                      input logic l, input logic r);
    logic hs, acc, comp;
    int w0, w1;
    in_valid = v; in_bit = b; in_last = l; out_ready = r;
    #1;
    exp_rdy  = !(mvalid && !r && (mn == W - 1 || l));
    obs_rdy0 = rdy0;
    obs_rdy1 = rdy1;
    @(posedge clk);
    hs   = mvalid && r;
    acc  = v && exp_rdy;
    comp = acc && (mn == W - 1 || l);
    if (hs) begin
      ms0 = ms0 + mw0;
      ms1 = ms1 + mw1;
    end
    if (acc) mbits[mn] = int'(b);
    if (comp) begin
      w0 = 0; w1 = 0;
      for (int i = 0; i <= mn; i++) begin
        w0 += mbits[i] * (2 ** i);
        w1 += mbits[i] * (2 ** (W - 1 - i));
      end
      mw0 = W'(w0); mw1 = W'(w1);
      mnb = mn + 1;
      mvalid = 1'b1;
      mn = 0;
    end else begin
      if (acc) mn++;
      if (hs) mvalid = 1'b0;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    do_reset();
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b expected 0", ov0, ov1);
    end
    checks++;
    if (od0 !== '0 || nb0 !== '0 || s0 !== '0 || s1 !== '0) begin
      errors++;
      $display("FAIL reset_regs: got data %h nbits %0d sum %h/%h expected 0",
               od0, nb0, s0, s1);
    end
  endtask

  task automatic test_lsb_msb();
    logic [7:0] pat = 8'h9C;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, 1'b1);
    checks++;
    if (ov0 !== 1'b1 || od0 !== 8'h9C || nb0 !== NW'(8)) begin
      errors++;
      $display("FAIL lsb_word: got v=%b %h n=%0d expected v=1 9c n=8",
               ov0, od0, nb0);
    end
    checks++;
    if (ov1 !== 1'b1 || od1 !== 8'h39 || nb1 !== NW'(8)) begin
      errors++;
      $display("FAIL msb_word: got v=%b %h n=%0d expected v=1 39 n=8",
               ov1, od1, nb1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (s0 !== 8'h9C || s1 !== 8'h39 || ov0 !== 1'b0) begin
      errors++;
      $display("FAIL first_sum: got %h/%h v=%b expected 9c/39 v=0",
               s0, s1, ov0);
    end
  endtask

  task automatic test_last();
    logic [7:0] pat = 8'h3A;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (od0 !== 8'h05 || nb0 !== NW'(3) || od1 !== 8'hA0 || nb1 !== NW'(3)) begin
      errors++;
      $display("FAIL short_word: got %h/%h n=%0d expected 05/a0 n=3",
               od0, od1, nb0);
    end
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, 1'b1);
    checks++;
    if (od0 !== 8'h3A || nb0 !== NW'(8) || od1 !== mw1) begin
      errors++;
      $display("FAIL after_short: got %h/%h n=%0d expected 3a/%h n=8",
               od0, od1, nb0, mw1);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (od0 !== 8'h01 || nb0 !== NW'(1) || s0 !== 8'h3F) begin
      errors++;
      $display("FAIL one_bit: got %h n=%0d sum %h expected 01 n=1 sum 3f",
               od0, nb0, s0);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat = 8'h9C;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_rdy0 !== 1'b1 || od0 !== 8'h9C) begin
        errors++;
        $display("FAIL bp_accept%0d: got rdy=%b %h expected rdy=1 9c",
                 i, obs_rdy0, od0);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_rdy0 !== 1'b0 || obs_rdy1 !== 1'b0 || od0 !== 8'h9C || s0 !== 8'h00) begin
      errors++;
      $display("FAIL bp_stall: got rdy=%b/%b %h sum %h expected rdy=0 9c sum 00",
               obs_rdy0, obs_rdy1, od0, s0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_rdy0 !== 1'b1 || ov0 !== 1'b1 || od0 !== 8'hFF || s0 !== 8'h9C) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b v=%b %h sum %h expected 1 1 ff 9c",
               obs_rdy0, ov0, od0, s0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (s0 !== 8'h9B || ov0 !== 1'b0 || s1 !== ms1) begin
      errors++;
      $display("FAIL bp_sum: got %h/%h v=%b expected 9b/%h v=0",
               s0, s1, ov0, ms1);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] pat = 16'h20F0;
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, pat[i], 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (s0 !== 8'h10 || s1 !== ms1) begin
      errors++;
      $display("FAIL wrap_sum: got %h/%h expected 10/%h", s0, s1, ms1);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat = 8'h9C;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || s0 !== 8'h00 || s1 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got v=%b/%b sum %h/%h expected 0 0 00 00",
               ov0, ov1, s0, s1);
    end
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, 1'b1);
    checks++;
    if (ov0 !== 1'b1 || od0 !== 8'h9C || nb0 !== NW'(8) || od1 !== 8'h39) begin
      errors++;
      $display("FAIL post_reset: got v=%b %h/%h n=%0d expected 1 9c/39 n=8",
               ov0, od0, od1, nb0);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));
      checks++;
      if (obs_rdy0 !== exp_rdy || obs_rdy1 !== exp_rdy || ov0 !== mvalid ||
          ov1 !== mvalid || s0 !== ms0 || s1 !== ms1 ||
          (mvalid && (od0 !== mw0 || od1 !== mw1 ||
                      nb0 !== NW'(mnb) || nb1 !== NW'(mnb)))) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand%0d: got rdy=%b v=%b %h/%h n=%0d s=%h/%h expected rdy=%b v=%b %h/%h n=%0d s=%h/%h",
                   c, obs_rdy0, ov0, od0, od1, nb0, s0, s1,
                   exp_rdy, mvalid, mw0, mw1, mnb, ms0, ms1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_msb();
    test_last();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
